// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port 16-bit word memory between an
// instruction-fetch port (IF, read-only) and a load/store port (D).
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   if_req/if_addr             fetch request and word address
//   if_ack/if_rdata            fetch completion pulse and registered data
//   d_req/d_we/d_addr/d_wdata  load/store request and operands
//   d_ack/d_rdata              load/store completion pulse and load data
//   mem_addr/mem_wdata/mem_wen memory address, write data, write strobe
//   mem_rdata                  memory combinational read data
//   busy                       arbiter is not idle
//   owner                      current or last grantee (0 = IF, 1 = D)
module mem_arbiter #(
    parameter int WAIT_CYCLES = 1,
    parameter int MAX_STARVE  = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [15:0] if_addr,
    output logic        if_ack,
    output logic [15:0] if_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [15:0] d_addr,
    input  logic [15:0] d_wdata,
    output logic        d_ack,
    output logic [15:0] d_rdata,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    output logic        mem_wen,
    input  logic [15:0] mem_rdata,
    output logic        busy,
    output logic        owner
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_DONE   = 2'd2;

    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES - 1);
    localparam logic [3:0] STARVE_MAX = 4'(MAX_STARVE);

    logic [1:0]  state_q, state_d;
    logic [3:0]  wait_q, wait_d;
    logic [3:0]  starve_q, starve_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic        we_q, we_d;
    logic        owner_q, owner_d;
    logic [15:0] if_rdata_q, if_rdata_d;
    logic [15:0] d_rdata_q, d_rdata_d;
    logic        grant_d;

    always_comb begin
        state_d    = state_q;
        wait_d     = wait_q;
        starve_d   = starve_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        we_d       = we_q;
        owner_d    = owner_q;
        if_rdata_d = if_rdata_q;
        d_rdata_d  = d_rdata_q;
        // D wins contention unless IF has been starved long enough.
        grant_d    = d_req && !(if_req && (starve_q == STARVE_MAX));

        case (state_q)
            S_IDLE: begin
                if (if_req || d_req) begin
                    state_d = S_ACCESS;
                    wait_d  = WAIT_INIT;
                    owner_d = grant_d;
                    if (grant_d) begin
                        addr_d  = d_addr;
                        wdata_d = d_wdata;
                        we_d    = d_we;
                        if (if_req && (starve_q != STARVE_MAX))
                            starve_d = starve_q + 4'd1;
                    end else begin
                        addr_d   = if_addr;
                        wdata_d  = 16'h0000;
                        we_d     = 1'b0;
                        starve_d = 4'd0;
                    end
                end
            end
            S_ACCESS: begin
                if (wait_q != 4'd0) begin
                    wait_d = wait_q - 4'd1;
                end else begin
                    // Capture read data at the closing edge of the access.
                    if (!we_q) begin
                        if (owner_q)
                            d_rdata_d = mem_rdata;
                        else
                            if_rdata_d = mem_rdata;
                    end
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            wait_q     <= 4'd0;
            starve_q   <= 4'd0;
            addr_q     <= 16'h0000;
            wdata_q    <= 16'h0000;
            we_q       <= 1'b0;
            owner_q    <= 1'b0;
            if_rdata_q <= 16'h0000;
            d_rdata_q  <= 16'h0000;
        end else begin
            state_q    <= state_d;
            wait_q     <= wait_d;
            starve_q   <= starve_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            we_q       <= we_d;
            owner_q    <= owner_d;
            if_rdata_q <= if_rdata_d;
            d_rdata_q  <= d_rdata_d;
        end
    end

    // Strobe only in the last ACCESS cycle of a store.
    assign mem_wen   = (state_q == S_ACCESS) && (wait_q == 4'd0) && we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign if_ack    = (state_q == S_DONE) && !owner_q;
    assign d_ack     = (state_q == S_DONE) && owner_q;
    assign if_rdata  = if_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign busy      = (state_q != S_IDLE);
    assign owner     = owner_q;

endmodule
